// File: rtl/rd_ddr_pkg.sv
// rd_ddr_pkg: definitions shared by the read-1 and read-2 DDR burst issuers.
//   rd_state_e      - issuer FSM state encoding (3 bits, ST_IDLE..ST_REQ)
//   BURST_SHIFT_DEF - default log2(bytes per burst): 16 beats x 32 B
//   ARLEN_W         - width of the AR burst-length field
//   OS_CNT_W        - width of the outstanding-burst counter
package rd_ddr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_POP  = 3'd1,
    ST_LAT1 = 3'd2,
    ST_LAT2 = 3'd3,
    ST_REQ  = 3'd4
  } rd_state_e;

  localparam int unsigned BURST_SHIFT_DEF = 9;
  localparam int unsigned ARLEN_W         = 8;
  localparam int unsigned OS_CNT_W        = 4;

endpackage

// File: rtl/rd_ddr_os_cnt.sv
// rd_ddr_os_cnt: saturating up/down count of bursts issued but not yet completed.
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_inc         - AR handshake (one burst issued)
//   i_dec         - burst_done pulse (one burst completed); ignored at zero
//   o_cnt         - current outstanding count
//   o_os_full     - count has reached MAX_OS, no further bursts may start
module rd_ddr_os_cnt
  import rd_ddr_pkg::*;
#(
  parameter int unsigned MAX_OS = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_inc,
  input  logic                i_dec,
  output logic [OS_CNT_W-1:0] o_cnt,
  output logic                o_os_full
);

  logic [OS_CNT_W-1:0] r_cnt;
  logic [OS_CNT_W-1:0] w_cnt_nxt;
  logic                w_dec_eff;

  // A completion with nothing outstanding is spurious and must not wrap the counter.
  assign w_dec_eff = i_dec && (r_cnt != '0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_inc && !w_dec_eff) begin
      if (r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
    end else if (!i_inc && w_dec_eff) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end

  assign o_cnt     = r_cnt;
  assign o_os_full = (32'(r_cnt) >= MAX_OS);

endmodule

// File: rtl/rd1_ddr_burst_issue.sv
// rd1_ddr_burst_issue: pops burst indices from the read-1 DDR address FIFO, turns each into
// a byte address (frame_base + index << BURST_SHIFT) and issues it as a DDR read request.
// Ports:
//   i_clk, i_rst     - clock, asynchronous active-high reset
//   i_enable         - permits a new pop (looked at in IDLE only)
//   i_frame_base     - frame buffer base, captured together with the index
//   i_fifo_rd_data   - FIFO data, valid two cycles after o_fifo_rd_en
//   i_fifo_rd_empty  - FIFO empty
//   o_fifo_rd_en     - one-cycle pop strobe
//   o_arvalid/o_araddr/o_arlen, i_arready - read-address request handshake
//   i_burst_done     - one pulse per completed burst
//   o_os_cnt         - outstanding burst count
//   o_busy           - transaction in progress or bursts outstanding
module rd1_ddr_burst_issue
  import rd_ddr_pkg::*;
#(
  parameter int unsigned IDX_W       = 10,
  parameter int unsigned DDR_ADDR_W  = 28,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned BURST_SHIFT = BURST_SHIFT_DEF,
  parameter int unsigned MAX_OS      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [DDR_ADDR_W-1:0] i_frame_base,
  input  logic [IDX_W-1:0]      i_fifo_rd_data,
  input  logic                  i_fifo_rd_empty,
  output logic                  o_fifo_rd_en,
  output logic                  o_arvalid,
  output logic [DDR_ADDR_W-1:0] o_araddr,
  output logic [ARLEN_W-1:0]    o_arlen,
  input  logic                  i_arready,
  input  logic                  i_burst_done,
  output logic [OS_CNT_W-1:0]   o_os_cnt,
  output logic                  o_busy
);

  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic                  r_arvalid;
  logic [DDR_ADDR_W-1:0] r_araddr;
  logic [DDR_ADDR_W-1:0] w_offset;
  logic [DDR_ADDR_W-1:0] w_araddr_nxt;
  logic                  w_pop;
  logic                  w_ar_hs;
  logic                  w_os_full;
  logic [OS_CNT_W-1:0]   w_os_cnt;

  // Truncation to DDR_ADDR_W makes the sum wrap modulo 2^DDR_ADDR_W.
  assign w_offset     = DDR_ADDR_W'(i_fifo_rd_data) << BURST_SHIFT;
  assign w_araddr_nxt = i_frame_base + w_offset;
  assign w_ar_hs      = r_arvalid && i_arready;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_enable && !i_fifo_rd_empty && !w_os_full) w_state_nxt = ST_POP;
      end
      ST_POP: begin
        w_pop       = 1'b1;
        w_state_nxt = ST_LAT1;
      end
      ST_LAT1: w_state_nxt = ST_LAT2;
      ST_LAT2: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (i_arready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // FIFO data lands in LAT2; address and valid go up together for REQ.
      if (r_state == ST_LAT2) begin
        r_araddr  <= w_araddr_nxt;
        r_arvalid <= 1'b1;
      end else if (w_ar_hs) begin
        r_arvalid <= 1'b0;
      end
    end
  end

  rd_ddr_os_cnt #(
    .MAX_OS (MAX_OS)
  ) u_os_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_inc     (w_ar_hs),
    .i_dec     (i_burst_done),
    .o_cnt     (w_os_cnt),
    .o_os_full (w_os_full)
  );

  assign o_fifo_rd_en = w_pop;
  assign o_arvalid    = r_arvalid;
  assign o_araddr     = r_araddr;
  assign o_arlen      = ARLEN_W'(BURST_LEN - 1);
  assign o_os_cnt     = w_os_cnt;
  assign o_busy       = (r_state != ST_IDLE) || (w_os_cnt != '0);

endmodule
